l2_addr_map_ctrl: RTL and testbench
===================================

Name: l2_addr_map_ctrl

Overview:
- Owns the L2 handler/packet address windows that drive the L2 crossbar's address-decode inputs.
- Applies new windows atomically. New AW/AR traffic from all requesters (PE, DMA) is gated, outstanding transactions are drained, then the map is swapped.
- Sits between the requesters' AW/AR channels and the crossbar. B/R are monitored only and pass around the block unchanged.

Parameters:
- AddrWidth, 32, L2 address width.
- NumPorts, 2, monitored requester ports (0=PE, 1=DMA).
- MaxOutstanding, 16, per-port per-direction outstanding limit; CntWidth = $clog2(MaxOutstanding+1).
- DefHndStart / DefHndEnd, 32'h1C00_0000 / 32'h1C04_0000, reset handler window [start,end).
- DefPktStart / DefPktEnd, 32'h1C10_0000 / 32'h1C20_0000, reset packet window.
- TimeoutCycles, 1024, drain timeout (optional feature only).

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  async active-low reset
- cfg_valid_i  in  1  new-map request valid
- cfg_ready_o  out  1  request accepted
- cfg_hnd_start_i, cfg_hnd_end_i, cfg_pkt_start_i, cfg_pkt_end_i  in  AddrWidth each  requested windows
- cfg_done_o  out  1  one-cycle completion pulse
- cfg_err_o  out  1  valid with cfg_done_o; 1 = rejected
- l2_hnd_start_addr_o, l2_hnd_end_addr_o, l2_pkt_start_addr_o, l2_pkt_end_addr_o  out  AddrWidth each  active map to crossbar
- aw_valid_i, ar_valid_i  in  NumPorts  from requesters
- aw_ready_o, ar_ready_o  out  NumPorts  to requesters
- aw_valid_o, ar_valid_o  out  NumPorts  to crossbar
- aw_ready_i, ar_ready_i  in  NumPorts  from crossbar
- b_valid_i, b_ready_i, r_valid_i, r_ready_i, r_last_i  in  NumPorts  completion monitors
- busy_o  out  1  not IDLE

Behaviour:
- Clock/reset: one clock clk_i; asynchronous active-low reset rst_ni.
- Reset values:
  - map outputs = Def* parameters; all counters 0; FSM IDLE.
  - cfg_ready_o=0, cfg_done_o=0, cfg_err_o=0, busy_o=0.
- Outstanding counters, per port:
  - wr_cnt: +1 on AW handshake (aw_valid_o & aw_ready_i), -1 on B handshake.
  - rd_cnt: +1 on AR handshake, -1 on R handshake with r_last_i.
  - Simultaneous +1 and -1 in the same cycle: no change. Decrement at 0 is impossible by protocol; assertion only, saturating at 0.
- Pending flag, per port per channel: set when valid_o & ~ready_i; cleared on handshake. Keeps AXI valid stable.
- Gating:
  - aw_valid_o = aw_valid_i & (pending | ~(stall | wr_cnt==MaxOutstanding)); aw_ready_o = aw_ready_i & aw_valid_o. AR identical.
  - A pending beat is never withdrawn.
  - stall is registered, asserted from DRAIN entry until RESP.
- FSM:
  - IDLE: cfg_ready_o=1. On cfg_valid_i, latch the shadow map and check validity: start<end for both windows, and windows disjoint (hnd_end<=pkt_start or pkt_end<=hnd_start).
    - Invalid -> RESP with err=1, no stall.
    - Valid -> DRAIN.
  - DRAIN: stall=1. When all wr_cnt, rd_cnt and pending flags are 0 -> COMMIT. Minimum 1 cycle in DRAIN.
  - COMMIT: 1 cycle; active map <= shadow; stall stays 1.
  - RESP: cfg_done_o=1 for one cycle, cfg_err_o as decided; stall released. Next state IDLE.
- Latency with zero traffic: accept (cycle 0) -> DRAIN (1) -> COMMIT (2) -> done pulse (3). Map outputs change at the edge ending COMMIT.
- A request equal to the current map is still processed normally.
- cfg_ready_o=0 outside IDLE; requests are held by the requester.
- Reset mid-operation: map returns to the defaults, the FSM goes IDLE and no cfg_done_o is issued. Counters clear and the system reset drains the crossbar.

Optional Feature:
- Macro: L2_MAP_CTRL_TIMEOUT_EN.
- Defined: a DRAIN cycle counter runs. Reaching TimeoutCycles -> RESP with cfg_err_o=1, map unchanged, stall released.
- Undefined: no counter; DRAIN waits indefinitely.

Decomposition:
- Package l2_map_pkg: addr_map_t struct (hnd_start, hnd_end, pkt_start, pkt_end), the FSM state enum, and the validity-check function map_valid().
- Sub-module l2_txn_tracker: one per port, handling wr/rd counters, pending flags, gating and idle_o.

Test Plan:
- Idle bus, request hnd=[0x1C000000,0x1C008000) and pkt=[0x1C100000,0x1C180000) -> cfg_done_o at cycle 3, err=0, outputs updated.
- Overlapping request hnd=[0x1000,0x3000), pkt=[0x2000,0x4000) -> done at cycle 1, err=1, map unchanged, aw_valid_o never gated.
- PE has 3 writes and 2 reads outstanding when the request arrives -> aw/ar_valid_o held 0. COMMIT occurs 1 cycle after the last B/R-last; new AWs then pass.
- AW stalled (aw_ready_i=0) when the request arrives -> aw_valid_o remains 1 until the handshake and is never dropped; drain then completes.
- DMA issues 16 ARs with no R -> 17th ar_valid_o=0 until one R-last is accepted.
- With L2_MAP_CTRL_TIMEOUT_EN and TimeoutCycles=1024, a B that never returns -> done with err=1 at DRAIN cycle 1024, map unchanged; a mid-DRAIN rst_ni pulse -> defaults restored, no done pulse.

Source files
------------

// File: rtl/l2_map_pkg.sv
// -----------------------------------------------------------------------------
// l2_map_pkg
// Shared types for the L2 address-map controller:
//   - addr_map_t  : handler and packet windows, each [start, end)
//   - map_state_e : controller FSM state encoding
//   - map_valid() : returns 1 when both windows are non-empty and disjoint
// -----------------------------------------------------------------------------
package l2_map_pkg;

  localparam int unsigned L2AddrWidth = 32;

  typedef logic [L2AddrWidth-1:0] l2_addr_t;

  typedef struct packed {
    l2_addr_t hnd_start;
    l2_addr_t hnd_end;
    l2_addr_t pkt_start;
    l2_addr_t pkt_end;
  } addr_map_t;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DRAIN  = 2'd1,
    ST_COMMIT = 2'd2,
    ST_RESP   = 2'd3
  } map_state_e;

  // Windows are half-open, so touching windows (end == other start) are legal.
  function automatic logic map_valid(input addr_map_t m);
    logic hnd_ok;
    logic pkt_ok;
    logic disjoint;
    hnd_ok   = (m.hnd_start < m.hnd_end);
    pkt_ok   = (m.pkt_start < m.pkt_end);
    disjoint = (m.hnd_end <= m.pkt_start) || (m.pkt_end <= m.hnd_start);
    return hnd_ok && pkt_ok && disjoint;
  endfunction

endpackage

// File: rtl/l2_txn_tracker.sv
// -----------------------------------------------------------------------------
// l2_txn_tracker
// One requester port: counts outstanding writes (AW..B) and reads (AR..R-last),
// remembers AW/AR beats presented but not yet accepted, and gates new AW/AR
// beats while stalled or at the outstanding limit.
//
// Handshake rule: a beat transfers on a cycle where valid and ready are both
// high at the rising edge. Once aw/ar_valid_o is raised it stays high until its
// handshake (the pending flag overrides stall and the limit).
//
// Ports:
//   clk_i, rst_ni                 clock, async active-low reset
//   stall_i                       block new AW/AR beats
//   aw_valid_i/aw_ready_o         requester AW side
//   aw_valid_o/aw_ready_i         crossbar AW side
//   ar_*                          same for AR
//   b_valid_i, b_ready_i          B handshake monitor
//   r_valid_i, r_ready_i, r_last_i  R handshake monitor (last beat retires)
//   idle_o                        no outstanding or pending traffic
// -----------------------------------------------------------------------------
module l2_txn_tracker #(
  parameter int unsigned MaxOutstanding = 16,
  parameter int unsigned CntWidth       = $clog2(MaxOutstanding + 1)
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic stall_i,
  input  logic aw_valid_i,
  output logic aw_ready_o,
  output logic aw_valid_o,
  input  logic aw_ready_i,
  input  logic ar_valid_i,
  output logic ar_ready_o,
  output logic ar_valid_o,
  input  logic ar_ready_i,
  input  logic b_valid_i,
  input  logic b_ready_i,
  input  logic r_valid_i,
  input  logic r_ready_i,
  input  logic r_last_i,
  output logic idle_o
);

  localparam logic [CntWidth-1:0] CntMax = CntWidth'(MaxOutstanding);

  logic [CntWidth-1:0] wr_cnt_q, wr_cnt_d;
  logic [CntWidth-1:0] rd_cnt_q, rd_cnt_d;
  logic                aw_pend_q, aw_pend_d;
  logic                ar_pend_q, ar_pend_d;
  logic                aw_hs, ar_hs, b_hs, r_hs;

  assign aw_valid_o = aw_valid_i & (aw_pend_q | ~(stall_i | (wr_cnt_q == CntMax)));
  assign ar_valid_o = ar_valid_i & (ar_pend_q | ~(stall_i | (rd_cnt_q == CntMax)));
  assign aw_ready_o = aw_ready_i & aw_valid_o;
  assign ar_ready_o = ar_ready_i & ar_valid_o;

  assign aw_hs = aw_valid_o & aw_ready_i;
  assign ar_hs = ar_valid_o & ar_ready_i;
  assign b_hs  = b_valid_i & b_ready_i;
  assign r_hs  = r_valid_i & r_ready_i & r_last_i;

  always_comb begin
    wr_cnt_d = wr_cnt_q;
    rd_cnt_d = rd_cnt_q;
    case ({aw_hs, b_hs})
      2'b10:   wr_cnt_d = wr_cnt_q + 1'b1;
      2'b01:   if (wr_cnt_q != '0) wr_cnt_d = wr_cnt_q - 1'b1;
      default: wr_cnt_d = wr_cnt_q;
    endcase
    case ({ar_hs, r_hs})
      2'b10:   rd_cnt_d = rd_cnt_q + 1'b1;
      2'b01:   if (rd_cnt_q != '0) rd_cnt_d = rd_cnt_q - 1'b1;
      default: rd_cnt_d = rd_cnt_q;
    endcase
    // Pending: presented to the crossbar but not accepted yet.
    aw_pend_d = aw_hs ? 1'b0 : (aw_valid_o ? 1'b1 : aw_pend_q);
    ar_pend_d = ar_hs ? 1'b0 : (ar_valid_o ? 1'b1 : ar_pend_q);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_cnt_q  <= '0;
      rd_cnt_q  <= '0;
      aw_pend_q <= 1'b0;
      ar_pend_q <= 1'b0;
    end else begin
      wr_cnt_q  <= wr_cnt_d;
      rd_cnt_q  <= rd_cnt_d;
      aw_pend_q <= aw_pend_d;
      ar_pend_q <= ar_pend_d;
    end
  end

  assign idle_o = (wr_cnt_q == '0) && (rd_cnt_q == '0) && !aw_pend_q && !ar_pend_q;

`ifndef SYNTHESIS
  a_no_b_underflow : assert property (@(posedge clk_i) disable iff (!rst_ni)
    b_hs |-> (wr_cnt_q != '0));
  a_no_r_underflow : assert property (@(posedge clk_i) disable iff (!rst_ni)
    r_hs |-> (rd_cnt_q != '0));
`endif

endmodule

// File: rtl/l2_addr_map_ctrl.sv
// -----------------------------------------------------------------------------
// l2_addr_map_ctrl
// Owns the L2 handler/packet address windows feeding the crossbar decoder and
// swaps them atomically: a request is checked, new AW/AR traffic is stalled,
// outstanding transactions drain, the map is committed, then done is pulsed.
// B and R are only observed.
//
// Config handshake: a request transfers on a cycle with cfg_valid_i and
// cfg_ready_o both high; the requester holds it until then. Completion is a
// single-cycle cfg_done_o with cfg_err_o qualifying it.
//
// Optional build macro L2_MAP_CTRL_TIMEOUT_EN: abandons a drain after
// TimeoutCycles cycles in DRAIN, answering with cfg_err_o=1 and the map unchanged.
//
// Ports:
//   clk_i, rst_ni                  clock, async active-low reset
//   cfg_valid_i/cfg_ready_o        new-map request
//   cfg_{hnd,pkt}_{start,end}_i    requested windows
//   cfg_done_o, cfg_err_o          completion pulse and reject flag
//   l2_{hnd,pkt}_{start,end}_addr_o  active map
//   aw/ar_valid_i, aw/ar_ready_o   requester side, per port (0=PE, 1=DMA)
//   aw/ar_valid_o, aw/ar_ready_i   crossbar side, per port
//   b_*/r_* inputs                 completion monitors, per port
//   busy_o                         controller not idle
//   dbg_state_o                    FSM state
// -----------------------------------------------------------------------------
module l2_addr_map_ctrl
  import l2_map_pkg::*;
#(
  parameter int unsigned          AddrWidth      = L2AddrWidth,
  parameter int unsigned          NumPorts       = 2,
  parameter int unsigned          MaxOutstanding = 16,
  parameter logic [AddrWidth-1:0] DefHndStart    = 32'h1C00_0000,
  parameter logic [AddrWidth-1:0] DefHndEnd      = 32'h1C04_0000,
  parameter logic [AddrWidth-1:0] DefPktStart    = 32'h1C10_0000,
  parameter logic [AddrWidth-1:0] DefPktEnd      = 32'h1C20_0000
`ifdef L2_MAP_CTRL_TIMEOUT_EN
  ,
  parameter int unsigned          TimeoutCycles  = 1024
`endif
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 cfg_valid_i,
  output logic                 cfg_ready_o,
  input  logic [AddrWidth-1:0] cfg_hnd_start_i,
  input  logic [AddrWidth-1:0] cfg_hnd_end_i,
  input  logic [AddrWidth-1:0] cfg_pkt_start_i,
  input  logic [AddrWidth-1:0] cfg_pkt_end_i,
  output logic                 cfg_done_o,
  output logic                 cfg_err_o,
  output logic [AddrWidth-1:0] l2_hnd_start_addr_o,
  output logic [AddrWidth-1:0] l2_hnd_end_addr_o,
  output logic [AddrWidth-1:0] l2_pkt_start_addr_o,
  output logic [AddrWidth-1:0] l2_pkt_end_addr_o,
  input  logic [NumPorts-1:0]  aw_valid_i,
  input  logic [NumPorts-1:0]  ar_valid_i,
  output logic [NumPorts-1:0]  aw_ready_o,
  output logic [NumPorts-1:0]  ar_ready_o,
  output logic [NumPorts-1:0]  aw_valid_o,
  output logic [NumPorts-1:0]  ar_valid_o,
  input  logic [NumPorts-1:0]  aw_ready_i,
  input  logic [NumPorts-1:0]  ar_ready_i,
  input  logic [NumPorts-1:0]  b_valid_i,
  input  logic [NumPorts-1:0]  b_ready_i,
  input  logic [NumPorts-1:0]  r_valid_i,
  input  logic [NumPorts-1:0]  r_ready_i,
  input  logic [NumPorts-1:0]  r_last_i,
  output logic                 busy_o,
  output map_state_e           dbg_state_o
);

  localparam int unsigned CntWidth = $clog2(MaxOutstanding + 1);

  map_state_e          state_q, state_d;
  addr_map_t           map_q, map_d;
  addr_map_t           shadow_q, shadow_d;
  addr_map_t           cfg_map;
  logic                stall_q, stall_d;
  logic                err_q, err_d;
  logic                ready_q, ready_d;
  logic                tmo_hit;
  logic [NumPorts-1:0] port_idle;
  logic                all_idle;

  assign cfg_map = '{hnd_start: cfg_hnd_start_i, hnd_end: cfg_hnd_end_i,
                     pkt_start: cfg_pkt_start_i, pkt_end: cfg_pkt_end_i};

  for (genvar p = 0; p < NumPorts; p++) begin : g_port
    l2_txn_tracker #(
      .MaxOutstanding (MaxOutstanding),
      .CntWidth       (CntWidth)
    ) u_tracker (
      .clk_i      (clk_i),
      .rst_ni     (rst_ni),
      .stall_i    (stall_q),
      .aw_valid_i (aw_valid_i[p]),
      .aw_ready_o (aw_ready_o[p]),
      .aw_valid_o (aw_valid_o[p]),
      .aw_ready_i (aw_ready_i[p]),
      .ar_valid_i (ar_valid_i[p]),
      .ar_ready_o (ar_ready_o[p]),
      .ar_valid_o (ar_valid_o[p]),
      .ar_ready_i (ar_ready_i[p]),
      .b_valid_i  (b_valid_i[p]),
      .b_ready_i  (b_ready_i[p]),
      .r_valid_i  (r_valid_i[p]),
      .r_ready_i  (r_ready_i[p]),
      .r_last_i   (r_last_i[p]),
      .idle_o     (port_idle[p])
    );
  end

  assign all_idle = &port_idle;

`ifdef L2_MAP_CTRL_TIMEOUT_EN
  localparam int unsigned TmoWidth = $clog2(TimeoutCycles + 1);
  logic [TmoWidth-1:0] tmo_q, tmo_d;

  // Counts completed DRAIN cycles; hit marks the last permitted one.
  assign tmo_d   = (state_q == ST_DRAIN) ? tmo_q + 1'b1 : '0;
  assign tmo_hit = (state_q == ST_DRAIN) && (tmo_q == TmoWidth'(TimeoutCycles - 1));

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) tmo_q <= '0;
    else         tmo_q <= tmo_d;
  end
`else
  assign tmo_hit = 1'b0;
`endif

  always_comb begin
    state_d  = state_q;
    map_d    = map_q;
    shadow_d = shadow_q;
    err_d    = err_q;
    unique case (state_q)
      ST_IDLE: begin
        if (cfg_valid_i && ready_q) begin
          shadow_d = cfg_map;
          if (map_valid(cfg_map)) begin
            err_d   = 1'b0;
            state_d = ST_DRAIN;
          end else begin
            err_d   = 1'b1;
            state_d = ST_RESP;
          end
        end
      end
      ST_DRAIN: begin
        // Drain completion wins over a coincident timeout.
        if (all_idle) begin
          state_d = ST_COMMIT;
        end else if (tmo_hit) begin
          err_d   = 1'b1;
          state_d = ST_RESP;
        end
      end
      ST_COMMIT: begin
        map_d   = shadow_q;
        err_d   = 1'b0;
        state_d = ST_RESP;
      end
      ST_RESP: begin
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    stall_d = (state_d == ST_DRAIN) || (state_d == ST_COMMIT);
    ready_d = (state_d == ST_IDLE);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= ST_IDLE;
      map_q    <= '{hnd_start: DefHndStart, hnd_end: DefHndEnd,
                    pkt_start: DefPktStart, pkt_end: DefPktEnd};
      shadow_q <= '0;
      stall_q  <= 1'b0;
      err_q    <= 1'b0;
      ready_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      map_q    <= map_d;
      shadow_q <= shadow_d;
      stall_q  <= stall_d;
      err_q    <= err_d;
      ready_q  <= ready_d;
    end
  end

  assign cfg_ready_o         = ready_q;
  assign cfg_done_o          = (state_q == ST_RESP);
  assign cfg_err_o           = (state_q == ST_RESP) && err_q;
  assign busy_o              = (state_q != ST_IDLE);
  assign dbg_state_o         = state_q;
  assign l2_hnd_start_addr_o = map_q.hnd_start;
  assign l2_hnd_end_addr_o   = map_q.hnd_end;
  assign l2_pkt_start_addr_o = map_q.pkt_start;
  assign l2_pkt_end_addr_o   = map_q.pkt_end;

endmodule

// File: tb/tb_l2_addr_map_ctrl.sv
module tb_l2_addr_map_ctrl;
  import l2_map_pkg::*;

  localparam int NP = 2;

  localparam logic [127:0] DEF_MAP = {32'h1C00_0000, 32'h1C04_0000, 32'h1C10_0000, 32'h1C20_0000};
  localparam logic [127:0] M1      = {32'h1C00_0000, 32'h1C00_8000, 32'h1C10_0000, 32'h1C18_0000};
  localparam logic [127:0] M2      = {32'h1C00_0000, 32'h1C01_0000, 32'h1C20_0000, 32'h1C30_0000};
  localparam logic [127:0] M_OVL   = {32'h0000_1000, 32'h0000_3000, 32'h0000_2000, 32'h0000_4000};
  localparam logic [127:0] M_EMPTY = {32'h0000_1000, 32'h0000_1000, 32'h0000_2000, 32'h0000_3000};
  localparam logic [127:0] M_REV   = {32'h0000_1000, 32'h0000_2000, 32'h0000_5000, 32'h0000_4000};
  localparam logic [127:0] M_TOUCH = {32'h0000_1000, 32'h0000_2000, 32'h0000_2000, 32'h0000_3000};
  localparam logic [127:0] M_BELOW = {32'h0000_5000, 32'h0000_6000, 32'h0000_1000, 32'h0000_5000};

  // clock / reset
  logic clk_i = 1'b0;
  logic rst_ni;
  always #5 clk_i = ~clk_i;

  logic          cfg_valid_i, cfg_ready_o, cfg_done_o, cfg_err_o, busy_o;
  logic [31:0]   cfg_hnd_start_i, cfg_hnd_end_i, cfg_pkt_start_i, cfg_pkt_end_i;
  logic [31:0]   l2_hnd_start_addr_o, l2_hnd_end_addr_o, l2_pkt_start_addr_o, l2_pkt_end_addr_o;
  logic [NP-1:0] aw_valid_i, ar_valid_i, aw_ready_o, ar_ready_o, aw_valid_o, ar_valid_o;
  logic [NP-1:0] aw_ready_i, ar_ready_i, b_valid_i, b_ready_i, r_valid_i, r_ready_i, r_last_i;
  map_state_e    dbg_state_o;

  l2_addr_map_ctrl dut (
    .clk_i               (clk_i),
    .rst_ni              (rst_ni),
    .cfg_valid_i         (cfg_valid_i),
    .cfg_ready_o         (cfg_ready_o),
    .cfg_hnd_start_i     (cfg_hnd_start_i),
    .cfg_hnd_end_i       (cfg_hnd_end_i),
    .cfg_pkt_start_i     (cfg_pkt_start_i),
    .cfg_pkt_end_i       (cfg_pkt_end_i),
    .cfg_done_o          (cfg_done_o),
    .cfg_err_o           (cfg_err_o),
    .l2_hnd_start_addr_o (l2_hnd_start_addr_o),
    .l2_hnd_end_addr_o   (l2_hnd_end_addr_o),
    .l2_pkt_start_addr_o (l2_pkt_start_addr_o),
    .l2_pkt_end_addr_o   (l2_pkt_end_addr_o),
    .aw_valid_i          (aw_valid_i),
    .ar_valid_i          (ar_valid_i),
    .aw_ready_o          (aw_ready_o),
    .ar_ready_o          (ar_ready_o),
    .aw_valid_o          (aw_valid_o),
    .ar_valid_o          (ar_valid_o),
    .aw_ready_i          (aw_ready_i),
    .ar_ready_i          (ar_ready_i),
    .b_valid_i           (b_valid_i),
    .b_ready_i           (b_ready_i),
    .r_valid_i           (r_valid_i),
    .r_ready_i           (r_ready_i),
    .r_last_i            (r_last_i),
    .busy_o              (busy_o),
    .dbg_state_o         (dbg_state_o)
  );

  // scoreboard
  int n_tests = 0;
  int n_fail  = 0;

  task automatic check_eq(input string tag, input logic [127:0] act, input logic [127:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  function automatic logic [127:0] cur_map();
    return {l2_hnd_start_addr_o, l2_hnd_end_addr_o, l2_pkt_start_addr_o, l2_pkt_end_addr_o};
  endfunction

  // driver tasks
  task automatic drive_idle();
    cfg_valid_i = 1'b0;
    {cfg_hnd_start_i, cfg_hnd_end_i, cfg_pkt_start_i, cfg_pkt_end_i} = '0;
    aw_valid_i = '0; ar_valid_i = '0; aw_ready_i = '0; ar_ready_i = '0;
    b_valid_i = '0; b_ready_i = '0; r_valid_i = '0; r_ready_i = '0; r_last_i = '0;
  endtask

  task automatic set_cfg(input logic [127:0] m);
    {cfg_hnd_start_i, cfg_hnd_end_i, cfg_pkt_start_i, cfg_pkt_end_i} = m;
  endtask

  // Presents a request, waits for acceptance, then counts negedges after the
  // accepting edge until cfg_done_o (1 = first cycle after acceptance).
  task automatic do_cfg(input logic [127:0] m, output int lat, output logic err);
    int k;
    @(negedge clk_i);
    set_cfg(m);
    cfg_valid_i = 1'b1;
    k = 0;
    while (!cfg_ready_o && k < 100) begin
      @(negedge clk_i);
      k++;
    end
    @(posedge clk_i);
    @(negedge clk_i);
    cfg_valid_i = 1'b0;
    lat = 1;
    while (!cfg_done_o && lat < 2000) begin
      @(negedge clk_i);
      lat++;
    end
    err = cfg_err_o;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int   lat;
    logic err;
    logic [127:0] exp_map;
    logic saw_done;

    drive_idle();
    rst_ni = 1'b0;
    repeat (2) @(negedge clk_i);
    aw_valid_i = 2'b11; ar_valid_i = 2'b11;
    #1;
    check_eq("rst_ready", cfg_ready_o, 0);
    check_eq("rst_done", cfg_done_o, 0);
    check_eq("rst_err", cfg_err_o, 0);
    check_eq("rst_busy", busy_o, 0);
    check_eq("rst_map", cur_map(), DEF_MAP);
    check_eq("rst_state", dbg_state_o, ST_IDLE);
    check_eq("rst_aw_pass", aw_valid_o, 2'b11);
    aw_valid_i = '0; ar_valid_i = '0;
    @(negedge clk_i);
    rst_ni = 1'b1;
    @(negedge clk_i);
    check_eq("idle_ready", cfg_ready_o, 1);

    // T1: valid request on an idle bus
    exp_map = M1;
    do_cfg(M1, lat, err);
    check_eq("t1_lat", lat, 3);
    check_eq("t1_err", err, 0);
    check_eq("t1_map", cur_map(), exp_map);
    @(negedge clk_i);
    check_eq("t1_done_1cyc", cfg_done_o, 0);
    check_eq("t1_busy_clr", busy_o, 0);

    // T2: overlapping request with AW traffic flowing
    @(negedge clk_i);
    aw_valid_i[0] = 1'b1; aw_ready_i[0] = 1'b1;
    set_cfg(M_OVL); cfg_valid_i = 1'b1;
    #1;
    check_eq("t2_aw_c0", aw_valid_o[0], 1);
    @(negedge clk_i);
    cfg_valid_i = 1'b0;
    check_eq("t2_done", cfg_done_o, 1);
    check_eq("t2_err", cfg_err_o, 1);
    check_eq("t2_aw_c1", aw_valid_o[0], 1);
    @(negedge clk_i);
    check_eq("t2_aw_c2", aw_valid_o[0], 1);
    check_eq("t2_map", cur_map(), exp_map);
    check_eq("t2_idle", busy_o, 0);
    // two AWs were accepted; return both Bs
    aw_valid_i[0] = 1'b0; aw_ready_i[0] = 1'b0;
    b_valid_i[0] = 1'b1; b_ready_i[0] = 1'b1;
    repeat (2) @(negedge clk_i);
    b_valid_i[0] = 1'b0; b_ready_i[0] = 1'b0;

    // boundary validity vectors
    do_cfg(M_EMPTY, lat, err);
    check_eq("empty_lat", lat, 1);
    check_eq("empty_err", err, 1);
    do_cfg(M_REV, lat, err);
    check_eq("rev_err", err, 1);
    check_eq("rev_map", cur_map(), exp_map);
    do_cfg(M_TOUCH, lat, err);
    exp_map = M_TOUCH;
    check_eq("touch_lat", lat, 3);
    check_eq("touch_err", err, 0);
    check_eq("touch_map", cur_map(), exp_map);
    do_cfg(M_BELOW, lat, err);
    exp_map = M_BELOW;
    check_eq("below_err", err, 0);
    check_eq("below_map", cur_map(), exp_map);

    // T3: 3 writes and 2 reads outstanding on PE
    @(negedge clk_i);
    aw_valid_i[0] = 1'b1; aw_ready_i[0] = 1'b1; ar_valid_i[0] = 1'b1; ar_ready_i[0] = 1'b1;
    @(negedge clk_i);
    @(negedge clk_i);
    ar_valid_i[0] = 1'b0; ar_ready_i[0] = 1'b0;
    @(negedge clk_i);
    aw_valid_i[0] = 1'b0;
    set_cfg(M1); cfg_valid_i = 1'b1;
    @(negedge clk_i);
    cfg_valid_i = 1'b0;
    aw_valid_i[0] = 1'b1; ar_valid_i[0] = 1'b1; aw_ready_i[0] = 1'b1; ar_ready_i[0] = 1'b1;
    #1;
    check_eq("t3_aw_gated0", aw_valid_o[0], 0);
    check_eq("t3_ar_gated0", ar_valid_o[0], 0);
    check_eq("t3_busy", busy_o, 1);
    b_valid_i[0] = 1'b1; b_ready_i[0] = 1'b1;
    r_valid_i[0] = 1'b1; r_ready_i[0] = 1'b1; r_last_i[0] = 1'b1;
    @(negedge clk_i);
    check_eq("t3_aw_gated1", aw_valid_o[0], 0);
    check_eq("t3_aw_rdy_gated", aw_ready_o[0], 0);
    @(negedge clk_i);
    r_valid_i[0] = 1'b0; r_ready_i[0] = 1'b0; r_last_i[0] = 1'b0;
    check_eq("t3_ar_gated2", ar_valid_o[0], 0);
    check_eq("t3_state_drain", dbg_state_o, ST_DRAIN);
    @(negedge clk_i);
    b_valid_i[0] = 1'b0; b_ready_i[0] = 1'b0;
    check_eq("t3_still_drain", dbg_state_o, ST_DRAIN);
    check_eq("t3_no_done_early", cfg_done_o, 0);
    @(negedge clk_i);
    check_eq("t3_commit", dbg_state_o, ST_COMMIT);
    check_eq("t3_aw_gated_commit", aw_valid_o[0], 0);
    check_eq("t3_map_old", cur_map(), exp_map);
    exp_map = M1;
    @(negedge clk_i);
    check_eq("t3_done", cfg_done_o, 1);
    check_eq("t3_err", cfg_err_o, 0);
    check_eq("t3_map_new", cur_map(), exp_map);
    check_eq("t3_aw_pass", aw_valid_o[0], 1);
    check_eq("t3_ar_pass", ar_valid_o[0], 1);
    @(negedge clk_i);
    aw_valid_i[0] = 1'b0; ar_valid_i[0] = 1'b0; aw_ready_i[0] = 1'b0; ar_ready_i[0] = 1'b0;
    b_valid_i[0] = 1'b1; b_ready_i[0] = 1'b1;
    r_valid_i[0] = 1'b1; r_ready_i[0] = 1'b1; r_last_i[0] = 1'b1;
    @(negedge clk_i);
    b_valid_i[0] = 1'b0; b_ready_i[0] = 1'b0;
    r_valid_i[0] = 1'b0; r_ready_i[0] = 1'b0; r_last_i[0] = 1'b0;

    // T4: AW stalled by crossbar when the request arrives
    @(negedge clk_i);
    aw_valid_i[0] = 1'b1; aw_ready_i[0] = 1'b0;
    set_cfg(M2); cfg_valid_i = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      @(negedge clk_i);
      cfg_valid_i = 1'b0;
      check_eq($sformatf("t4_aw_held%0d", i), aw_valid_o[0], 1);
    end
    aw_ready_i[0] = 1'b1;
    @(negedge clk_i);
    check_eq("t4_aw_gated_after_hs", aw_valid_o[0], 0);
    aw_valid_i[0] = 1'b0; aw_ready_i[0] = 1'b0;
    b_valid_i[0] = 1'b1; b_ready_i[0] = 1'b1;
    @(negedge clk_i);
    b_valid_i[0] = 1'b0; b_ready_i[0] = 1'b0;
    check_eq("t4_no_done_drain", cfg_done_o, 0);
    @(negedge clk_i);
    check_eq("t4_no_done_commit", cfg_done_o, 0);
    exp_map = M2;
    @(negedge clk_i);
    check_eq("t4_done", cfg_done_o, 1);
    check_eq("t4_map", cur_map(), exp_map);

    // T5: DMA read limit
    @(negedge clk_i);
    ar_valid_i[1] = 1'b1; ar_ready_i[1] = 1'b1;
    #1;
    for (int i = 1; i <= 16; i++) begin
      check_eq($sformatf("t5_ar_pass%0d", i), ar_valid_o[1], 1);
      @(negedge clk_i);
    end
    check_eq("t5_ar17_blocked", ar_valid_o[1], 0);
    check_eq("t5_ar17_rdy", ar_ready_o[1], 0);
    r_valid_i[1] = 1'b1; r_ready_i[1] = 1'b1; r_last_i[1] = 1'b0;
    @(negedge clk_i);
    check_eq("t5_nonlast_no_retire", ar_valid_o[1], 0);
    r_last_i[1] = 1'b1;
    @(negedge clk_i);
    check_eq("t5_ar_after_rlast", ar_valid_o[1], 1);
    ar_valid_i[1] = 1'b0; ar_ready_i[1] = 1'b0;
    repeat (15) @(negedge clk_i);
    r_valid_i[1] = 1'b0; r_ready_i[1] = 1'b0; r_last_i[1] = 1'b0;

    // T6: request equal to the current map
    do_cfg(M2, lat, err);
    check_eq("t6_lat", lat, 3);
    check_eq("t6_err", err, 0);
    check_eq("t6_map", cur_map(), exp_map);

    // leave one DMA write outstanding
    @(negedge clk_i);
    aw_valid_i[1] = 1'b1; aw_ready_i[1] = 1'b1;
    @(negedge clk_i);
    aw_valid_i[1] = 1'b0; aw_ready_i[1] = 1'b0;

`ifdef L2_MAP_CTRL_TIMEOUT_EN
    // T7: B never returns
    do_cfg(M1, lat, err);
    check_eq("t7_tmo_lat", lat, 1025);
    check_eq("t7_tmo_err", err, 1);
    check_eq("t7_tmo_map", cur_map(), exp_map);
    @(negedge clk_i);
    aw_valid_i[0] = 1'b1;
    #1;
    check_eq("t7_stall_released", aw_valid_o[0], 1);
    aw_valid_i[0] = 1'b0;
`endif

    // T8: reset in the middle of DRAIN
    @(negedge clk_i);
    set_cfg(M1); cfg_valid_i = 1'b1;
    @(negedge clk_i);
    cfg_valid_i = 1'b0;
    repeat (3) @(negedge clk_i);
    check_eq("t8_in_drain", dbg_state_o, ST_DRAIN);
    rst_ni = 1'b0;
    #1;
    check_eq("t8_map_def", cur_map(), DEF_MAP);
    check_eq("t8_done", cfg_done_o, 0);
    check_eq("t8_busy", busy_o, 0);
    @(negedge clk_i);
    rst_ni = 1'b1;
    saw_done = 1'b0;
    repeat (6) begin
      @(negedge clk_i);
      if (cfg_done_o) saw_done = 1'b1;
    end
    check_eq("t8_no_done_pulse", saw_done, 0);
    exp_map = M1;
    do_cfg(M1, lat, err);
    check_eq("t8_cnt_cleared_lat", lat, 3);
    check_eq("t8_map", cur_map(), exp_map);

    // report
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
